// File: rtl/alu_issue_ctrl.sv
// Issue controller between the decoder and the ALU execution units: formats operands,
// waits a fixed unit latency, captures the result and holds it until downstream takes it.
module alu_issue_ctrl #(
    parameter int unsigned UNIT_LATENCY = 1
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [4:0]  in_op,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [4:0]  Instruction_to_ALU,
    input  logic [31:0] unit_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_op
);

    // state  | meaning
    // IDLE   | no operation held, ready to accept
    // EXEC   | operands driven to the units, counting unit latency
    // DONE   | result captured, waiting for res_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAT   = 4'(UNIT_LATENCY);
    localparam logic [4:0] OP_SLL = 5'd8;
    localparam logic [4:0] OP_SRL = 5'd12;
    localparam logic [4:0] OP_SRA = 5'd13;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dat1_q, dat1_d;
    logic [31:0] dat2_q, dat2_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] res_data_q, res_data_d;
    logic [4:0]  res_op_q, res_op_d;

    logic [31:0] operand2;
    logic [31:0] operand2_fmt;
    logic        is_shift;

    assign operand2     = in_use_imm ? in_imm : in_rs2;
    assign is_shift     = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
    assign operand2_fmt = is_shift ? {27'b0, operand2[4:0]} : operand2;

    assign in_ready = !reset && ((state_q == S_IDLE) || ((state_q == S_DONE) && res_ready));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dat1_d     = dat1_q;
        dat2_d     = dat2_q;
        op_d       = op_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dat1_d  = in_rs1;
                        dat2_d  = operand2_fmt;
                        op_d    = in_op;
                        cnt_d   = 4'd0;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == LAT) begin
                        res_data_d = unit_result;
                        res_op_d   = op_q;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    // Accepting straight out of DONE keeps the issue stream bubble-free
                    if (res_ready) begin
                        if (in_valid) begin
                            dat1_d  = in_rs1;
                            dat2_d  = operand2_fmt;
                            op_d    = in_op;
                            cnt_d   = 4'd0;
                            state_d = S_EXEC;
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            dat1_q     <= 32'h0;
            dat2_q     <= 32'h0;
            op_q       <= 5'h0;
            res_data_q <= 32'h0;
            res_op_q   <= 5'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dat1_q     <= dat1_d;
            dat2_q     <= dat2_d;
            op_q       <= op_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
        end
    end

    assign dat_ready          = (state_q == S_EXEC);
    assign res_valid          = (state_q == S_DONE);
    assign ALU_dat1           = dat1_q;
    assign ALU_dat2           = dat2_q;
    assign Instruction_to_ALU = op_q;
    assign res_data           = res_data_q;
    assign res_op             = res_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a registered execution-unit model
// and a reference model computing expected operands, results and timing.
module tb_alu_issue_ctrl;

    localparam int LAT = 3;

    logic        soc_clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_rs1 = 32'h0;
    logic [31:0] in_rs2 = 32'h0;
    logic [31:0] in_imm = 32'h0;
    logic        in_use_imm = 1'b0;
    logic [4:0]  in_op = 5'h0;
    logic        dat_ready;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] unit_result = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [4:0]  res_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  op;
    } op_t;

    op_t q[$];

    alu_issue_ctrl #(.UNIT_LATENCY(LAT)) dut (
        .soc_clk(soc_clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_op(in_op),
        .dat_ready(dat_ready), .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
        .Instruction_to_ALU(Instruction_to_ALU), .unit_result(unit_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op)
    );

    always #5 soc_clk = ~soc_clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
        case (op)
            5'd0:    return a + b;
            5'd8:    return a << b[4:0];
            5'd12:   return a >> b[4:0];
            5'd13:   return $unsigned($signed(a) >>> b[4:0]);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] exp_dat2(input op_t o);
        logic [31:0] b;
        b = o.use_imm ? o.imm : o.rs2;
        if (o.op == 5'd8 || o.op == 5'd12 || o.op == 5'd13) return {27'b0, b[4:0]};
        return b;
    endfunction

    function automatic logic [31:0] exp_res(input op_t o);
        return alu_fn(o.rs1, o.use_imm ? o.imm : o.rs2, o.op);
    endfunction

    // Execution unit: registered result of whatever operands are presented
    always @(posedge soc_clk) unit_result <= alu_fn(ALU_dat1, ALU_dat2, Instruction_to_ALU);

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic present(input op_t o);
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
        in_use_imm = o.use_imm; in_op = o.op; in_valid = 1'b1;
    endtask

    function automatic op_t rand_op();
        op_t o;
        int sel;
        o.rs1 = $urandom; o.rs2 = $urandom; o.imm = $urandom;
        o.use_imm = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 4);
        case (sel)
            0: o.op = 5'd0;
            1: o.op = 5'd8;
            2: o.op = 5'd12;
            3: o.op = 5'd13;
            default: o.op = 5'($urandom_range(0, 31));
        endcase
        return o;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if ({dat_ready, res_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, res_data, res_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got dr=%b rv=%b d1=%h d2=%h op=%h rd=%h rop=%h exp all zero",
                     dat_ready, res_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, res_data, res_op);
        end
        in_valid = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    // Runs the queued operations back to back, accepting each new one from DONE
    task automatic run_stream(input string name);
        op_t o;
        while (q.size() > 0) begin
            o = q.pop_front();
            present(o);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got=%b exp=1", name, in_ready); end
            tick();
            checks++;
            if (dat_ready !== 1'b1 || ALU_dat1 !== o.rs1 || ALU_dat2 !== exp_dat2(o) || Instruction_to_ALU !== o.op) begin
                errors++;
                $display("FAIL %s issue got dr=%b d1=%h d2=%h op=%0d exp dr=1 d1=%h d2=%h op=%0d",
                         name, dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU, o.rs1, exp_dat2(o), o.op);
            end
            for (int k = 1; k <= LAT; k++) begin
                tick();
                checks++;
                if (dat_ready !== 1'b1 || res_valid !== 1'b0 || ALU_dat2 !== exp_dat2(o)) begin
                    errors++;
                    $display("FAIL %s exec_window k=%0d got dr=%b rv=%b d2=%h exp dr=1 rv=0 d2=%h",
                             name, k, dat_ready, res_valid, ALU_dat2, exp_dat2(o));
                end
            end
            tick();
            checks++;
            if (res_valid !== 1'b1 || dat_ready !== 1'b0 || res_data !== exp_res(o) || res_op !== o.op) begin
                errors++;
                $display("FAIL %s result got rv=%b dr=%b rd=%h rop=%0d exp rv=1 dr=0 rd=%h rop=%0d",
                         name, res_valid, dat_ready, res_data, res_op, exp_res(o), o.op);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b0 || dat_ready !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s to_idle got rv=%b dr=%b ir=%b exp 0 0 1", name, res_valid, dat_ready, in_ready);
        end
    endtask

    task automatic test_directed();
        q.push_back('{rs1: 32'h00000001, rs2: 32'hFFFFFFE4, imm: 32'h0, use_imm: 1'b0, op: 5'd8});
        q.push_back('{rs1: 32'h80000000, rs2: 32'h0, imm: 32'hFFFFFFFF, use_imm: 1'b1, op: 5'd13});
        q.push_back('{rs1: 32'h00000005, rs2: 32'h12345678, imm: 32'hDEADBEEF, use_imm: 1'b0, op: 5'd0});
        q.push_back('{rs1: 32'hF0000000, rs2: 32'h00000024, imm: 32'h0, use_imm: 1'b0, op: 5'd12});
        run_stream("directed");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) q.push_back(rand_op());
        run_stream("random");
    endtask

    task automatic test_backpressure();
        op_t a, b;
        logic [31:0] held;
        a = rand_op(); b = rand_op();
        res_ready = 1'b0;
        present(a);
        tick();
        present(b);
        repeat (LAT + 1) tick();
        held = exp_res(a);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== held || res_op !== a.op || in_ready !== 1'b0 || dat_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got rv=%b rd=%h rop=%0d ir=%b dr=%b exp rv=1 rd=%h rop=%0d ir=0 dr=0",
                         i, res_valid, res_data, res_op, in_ready, dat_ready, held, a.op);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (dat_ready !== 1'b1 || res_valid !== 1'b0 || ALU_dat1 !== b.rs1 || ALU_dat2 !== exp_dat2(b)) begin
            errors++;
            $display("FAIL bp_next_accept got dr=%b rv=%b d1=%h d2=%h exp dr=1 rv=0 d1=%h d2=%h",
                     dat_ready, res_valid, ALU_dat1, ALU_dat2, b.rs1, exp_dat2(b));
        end
        repeat (LAT + 1) tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp_res(b) || res_op !== b.op) begin
            errors++;
            $display("FAIL bp_next_result got rv=%b rd=%h rop=%0d exp rv=1 rd=%h rop=%0d",
                     res_valid, res_data, res_op, exp_res(b), b.op);
        end
        tick();
    endtask

    task automatic test_flush();
        op_t a, b;
        logic [31:0] prev;
        logic        seen;
        a = rand_op(); b = rand_op();
        prev = res_data;
        present(a);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (dat_ready !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_exec got dr=%b rv=%b ir=%b exp 0 0 1", dat_ready, res_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            if (res_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || res_data !== prev) begin
            errors++;
            $display("FAIL flush_no_result got seen=%b rd=%h exp seen=0 rd=%h", seen, res_data, prev);
        end
        res_ready = 1'b0;
        present(b);
        tick();
        in_valid = 1'b0;
        repeat (LAT + 1) tick();
        present(a);
        res_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (dat_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== exp_res(b) || res_op !== b.op) begin
            errors++;
            $display("FAIL flush_done got dr=%b rv=%b rd=%h rop=%0d exp dr=0 rv=0 rd=%h rop=%0d",
                     dat_ready, res_valid, res_data, res_op, exp_res(b), b.op);
        end
    endtask

    task automatic test_reset_mid();
        op_t a;
        a = rand_op();
        a.rs1 = a.rs1 | 32'h1;
        res_ready = 1'b0;
        present(a);
        tick();
        in_valid = 1'b0;
        repeat (LAT + 1) tick();
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_done got rv=%b exp=1", res_valid); end
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++;
        if ({dat_ready, res_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, res_data, res_op} !== '0) begin
            errors++;
            $display("FAIL rst_done_outputs got dr=%b rv=%b d1=%h d2=%h op=%h rd=%h rop=%h exp all zero",
                     dat_ready, res_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, res_data, res_op);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
        present(a);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dat_ready !== 1'b0 || ALU_dat1 !== 32'h0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_exec got dr=%b d1=%h rv=%b exp 0 0 0", dat_ready, ALU_dat1, res_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
